// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD to binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         BCD_DIGIT_W    = 4;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] BCD_ADJ_VAL    = 4'd3;

  // Smallest w with 2**w > 10**ndigits - 1.
  function automatic int bin_width(input int ndigits);
    longint m;
    int     w;
    m = 1;
    for (int i = 0; i < ndigits; i++)
      m = m * 10;
    w = 0;
    while ((longint'(1) << w) <= m - 1)
      w++;
    return w;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step of the reverse double-dabble.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= BCD_ADJ_THRESH) ? d - BCD_ADJ_VAL : d;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Iterative packed-BCD to binary converter, one bit per clock.
// Optional nibble check enabled by defining BCD2BIN_ERR_CHECK_EN.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 8,
  parameter int BIN_W   = 27
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [BCD_DIGIT_W*NDIGITS-1:0] bcd_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [BIN_W-1:0]               bin_out,
  output logic                           busy,
  output logic                           bcd_err
);

  localparam int DW = BCD_DIGIT_W * NDIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  if (BIN_W < bin_width(NDIGITS)) begin : g_bw_chk
    $error("BIN_W too small for NDIGITS");
  end

  state_t          state_q, state_d;
  logic [DW-1:0]   dig_q, dig_sh, dig_adj;
  logic [BIN_W-1:0] bin_q, bin_sh;
  logic [CW-1:0]   cnt_q;
  logic            rdy_q;
  logic            ov_q;
  logic            accept;

  assign in_ready  = rdy_q && (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q == SHIFT);
  assign out_valid = ov_q;
  assign bin_out   = bin_q;

  // Digit LSB falls into the top of the binary register.
  assign {dig_sh, bin_sh} = {1'b0, dig_q, bin_q[BIN_W-1:1]};

  for (genvar i = 0; i < NDIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (dig_sh[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .q (dig_adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(BIN_W - 1)) state_d = DONE;
      DONE:    if (ov_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dig_q <= '0;
      bin_q <= '0;
      cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          dig_q <= bcd_in;
          bin_q <= '0;
          cnt_q <= '0;
        end
        SHIFT: begin
          dig_q <= dig_adj;
          bin_q <= bin_sh;
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_q <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (ov_q && out_ready)
        ov_q <= 1'b0;
      else if (state_q == DONE)
        ov_q <= 1'b1;
    end
  end

`ifdef BCD2BIN_ERR_CHECK_EN
  logic err_q;
  logic bad;

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < NDIGITS; i++)
      if (bcd_in[BCD_DIGIT_W*i +: BCD_DIGIT_W] > 4'd9)
        bad = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       err_q <= 1'b0;
    else if (accept) err_q <= bad;
  end

  assign bcd_err = err_q;
`else
  assign bcd_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq with immediate assertions.
module tb_bcd_to_bin_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] bcd_in;
  logic        out_valid;
  logic        out_ready;
  logic [26:0] bin_out;
  logic        busy;
  logic        bcd_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_to_bin_seq #(.NDIGITS(8), .BIN_W(27)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .busy      (busy),
    .bcd_err   (bcd_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bcd2bin(input logic [31:0] b);
    logic [31:0] v;
    v = 0;
    for (int i = 7; i >= 0; i--)
      v = v * 10 + 32'(b[4*i +: 4]);
    return v;
  endfunction

  // Leaves in_valid high; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] bcd);
    bit got;
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    bcd_in = bcd;
    for (int i = 0; i < 64 && !acc; i++) begin
      got = in_ready;
      @(posedge clk);
      #1;
      acc = got;
    end
    chk("accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic convert(input logic [31:0] bcd, input logic [31:0] exp,
                         input logic err);
    int lat;
    send(bcd);
    in_valid = 1'b0;
    wait_out(lat);
    chk("latency", 32'(lat), 32'd28);
    chk("result", 32'(bin_out), exp);
    chk("err", 32'(bcd_err), 32'(err));
    @(posedge clk);
    #1;
    chk("released", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int          lat;
    logic [31:0] b;
    logic [31:0] e;

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    bcd_in = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_bin_out", 32'(bin_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(bcd_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    convert(32'h0000_1234, 32'd1234, 1'b0);
    convert(32'h9999_9999, 32'h05F5_E0FF, 1'b0);
    convert(32'h0000_0000, 32'd0, 1'b0);
    convert(32'h0000_0001, 32'd1, 1'b0);

    // Consumer stall with a competing request.
    out_ready = 1'b0;
    send(32'h0000_5678);
    in_valid = 1'b0;
    wait_out(lat);
    chk("stall_latency", 32'(lat), 32'd28);
    in_valid = 1'b1;
    bcd_in = 32'h0000_1111;
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(bin_out), 32'd5678);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_busy", 32'(busy), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release", 32'(out_valid), 32'd0);
    chk("stall_idle", 32'(in_ready), 32'd1);
    chk("stall_no_start", 32'(busy), 32'd0);

    // Abort mid-conversion.
    send(32'h0000_1234);
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    chk("pre_abort_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_bin_out", 32'(bin_out), 32'd0);
    chk("abort_err", 32'(bcd_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    convert(32'h0000_0042, 32'd42, 1'b0);

`ifdef BCD2BIN_ERR_CHECK_EN
    send(32'h0000_00A5);
    in_valid = 1'b0;
    wait_out(lat);
    chk("err_latency", 32'(lat), 32'd28);
    chk("err_set", 32'(bcd_err), 32'd1);
    @(posedge clk);
    #1;
    convert(32'h0000_0095, 32'd95, 1'b0);
`endif

    // Back-to-back with in_valid held high.
    for (int k = 0; k < 100; k++) begin
      b = '0;
      for (int d = 0; d < 8; d++)
        b[4*d +: 4] = 4'($urandom_range(0, 9));
      e = bcd2bin(b);
      send(b);
      bcd_in = 32'h9999_9999;
      wait_out(lat);
      chk("b2b_latency", 32'(lat), 32'd28);
      chk("b2b_result", 32'(bin_out), e);
      @(posedge clk);
      #1;
      chk("b2b_release", 32'(out_valid), 32'd0);
      chk("b2b_idle", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
